// File: rtl/vector_packer_pkg.sv
// ============================================================================
// Module   : vector_packer_pkg
// Purpose  : State encoding and sizing helper shared by the vector packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vector_packer_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Width needed to represent a count from 0 to num_fields inclusive.
    function automatic int count_width(input int num_fields);
        return $clog2(num_fields + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vector_packer.sv
// ============================================================================
// Module   : vector_packer
// Purpose  : Collects NUM_FIELDS narrow fields into one wide vector and holds
//            it until the consumer takes it. Define VECTOR_PACKER_PAD_EN to
//            add in_last for zero-padded short vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_packer
    import vector_packer_pkg::*;
#(
    parameter int FIELD_W    = 4,
    parameter int NUM_FIELDS = 4
) (
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic                                   flush,
    input  logic                                   in_valid,
    input  logic [FIELD_W-1:0]                     in_data,
    output logic                                   in_ready,
`ifdef VECTOR_PACKER_PAD_EN
    input  logic                                   in_last,
`endif
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [FIELD_W*NUM_FIELDS-1:0]          out_vec,
    output logic [count_width(NUM_FIELDS)-1:0]     fill_count
);

    localparam int            CW       = count_width(NUM_FIELDS);
    localparam int            VW       = FIELD_W * NUM_FIELDS;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_FIELDS - 1);

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [VW-1:0] vec,   vec_n;
    logic          accept;
    logic          last_field;

    always_comb begin
        in_ready = (state == FILL) && !flush;
        accept   = in_valid && in_ready;
`ifdef VECTOR_PACKER_PAD_EN
        last_field = (count == LAST_IDX) || in_last;
`else
        last_field = (count == LAST_IDX);
`endif
        state_n = state;
        count_n = count;
        vec_n   = vec;
        case (state)
            FILL: begin
                if (flush) begin
                    count_n = '0;
                    vec_n   = '0;
                end else if (accept) begin
                    vec_n[count*FIELD_W +: FIELD_W] = in_data;
                    count_n = count + 1'b1;
                    if (last_field) begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                // Flush and handshake both release the vector the same way.
                if (flush || out_ready) begin
                    state_n = FILL;
                    count_n = '0;
                    vec_n   = '0;
                end
            end
            default: begin
                state_n = FILL;
                count_n = '0;
                vec_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= FILL;
            count <= '0;
            vec   <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            vec   <= vec_n;
        end
    end

    assign out_valid  = (state == HOLD);
    assign out_vec    = vec;
    assign fill_count = count;

endmodule

`default_nettype wire

// File: tb/tb_vector_packer.sv
// ============================================================================
// Module   : tb_vector_packer
// Purpose  : Self-checking bench for vector_packer (FIELD_W=4, NUM_FIELDS=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_packer;

    localparam int FW = 4;
    localparam int NF = 4;
`ifdef VECTOR_PACKER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_data = '0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_vec;
    logic [2:0]    fill_count;

    int   total = 0;
    int   bad   = 0;
    logic obs_ready;

    // Reference model: the fields of the current vector and whether it is held.
    int fields[$];
    bit held;

    vector_packer #(.FIELD_W(FW), .NUM_FIELDS(NF)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
`ifdef VECTOR_PACKER_PAD_EN
        .in_last    (in_last),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_vec();
        logic [15:0] v = '0;
        for (int k = 0; k < fields.size(); k++) v = v + (16'(fields[k]) << (FW * k));
        return v;
    endfunction

    function automatic void model_reset();
        fields.delete();
        held = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [FW-1:0] d, input logic l,
                                       input logic f, input logic r);
        if (!held) begin
            if (f) fields.delete();
            else if (v) begin
                fields.push_back(int'(d));
                if (fields.size() == NF || (PAD && l)) held = 1'b1;
            end
        end else if (f || r) begin
            fields.delete();
            held = 1'b0;
        end
    endfunction

    // One clock: apply inputs, sample in_ready before the edge, settle after it.
    task automatic drive(input logic v, input logic [FW-1:0] d, input logic l,
                         input logic f, input logic r);
        in_valid = v; in_data = d; in_last = l; flush = f; out_ready = r;
        #1 obs_ready = in_ready;
        @(posedge clk);
        model_step(v, d, l, f, r);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_vec !== 16'h0) begin bad++; $display("FAIL reset_vec got=%h exp=0000", out_vec); end
        total++; if (fill_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fill_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1 resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, FW'(k), 1'b0, 1'b0, 1'b1);
            if (k < 4) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid k=%0d got=%b exp=0", k, out_valid); end
                total++; if (fill_count !== 3'(k)) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", fill_count, k); end
            end
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_vec !== 16'h4321) begin bad++; $display("FAIL basic_vec got=%h exp=4321", out_vec); end
        total++; if (fill_count !== 3'd4) begin bad++; $display("FAIL basic_hold_count got=%0d exp=4", fill_count); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++; if (fill_count !== 3'd0) begin bad++; $display("FAIL basic_after_count got=%0d exp=0", fill_count); end
        total++; if (out_valid !== 1'b0 || out_vec !== 16'h0) begin bad++; $display("FAIL basic_after got=%b/%h exp=0/0000", out_valid, out_vec); end
    endtask

    task automatic test_backpressure();
        for (int k = 5; k <= 8; k++) drive(1'b1, FW'(k), 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            total++; if (out_vec !== 16'h8765 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/8765", c, out_valid, out_vec); end
            drive(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
            total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, obs_ready); end
        end
        total++; if (out_vec !== 16'h8765 || fill_count !== 3'd4) begin bad++; $display("FAIL bp_stable got=%h/%0d exp=8765/4", out_vec, fill_count); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_transfer got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'hF, 1'b0, 1'b1, 1'b1);
        total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", obs_ready); end
        total++; if (fill_count !== 3'd0 || out_vec !== 16'h0) begin bad++; $display("FAIL flush_clear got=%0d/%h exp=0/0000", fill_count, out_vec); end
        for (int k = 10; k <= 13; k++) drive(1'b1, FW'(k), 1'b0, 1'b0, 1'b0);
        total++; if (out_vec !== 16'hDCBA || out_valid !== 1'b1) begin bad++; $display("FAIL flush_refill got=%b/%h exp=1/dcba", out_valid, out_vec); end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b0 || out_vec !== 16'h0) begin bad++; $display("FAIL flush_hold got=%b/%h exp=0/0000", out_valid, out_vec); end
    endtask

    task automatic test_reset_hold();
        for (int k = 4; k >= 1; k--) drive(1'b1, FW'(k), 1'b0, 1'b0, 1'b0);
        total++; if (out_vec !== 16'h1234) begin bad++; $display("FAIL rh_vec got=%h exp=1234", out_vec); end
        resetN = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_vec !== 16'h0 || fill_count !== 3'd0) begin
            bad++; $display("FAIL rh_clear got=%b/%h/%0d exp=0/0000/0", out_valid, out_vec, fill_count); end
        @(posedge clk); #1 resetN = 1'b1;
        model_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rh_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_pad();
        drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
        total++; if (out_vec !== 16'h0087 || fill_count !== 3'd2 || out_valid !== 1'b1) begin
            bad++; $display("FAIL pad_short got=%b/%h/%0d exp=1/0087/2", out_valid, out_vec, fill_count); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) drive(1'b1, FW'(k + 2), (k == 4), 1'b0, 1'b0);
        total++; if (out_vec !== 16'h6543 || fill_count !== 3'd4) begin bad++; $display("FAIL pad_full got=%h/%0d exp=6543/4", out_vec, fill_count); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic v, l, f, r, exp_ready;
        logic [FW-1:0] d;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom % 4) != 0;
            d = FW'($urandom);
            l = PAD && (($urandom % 4) == 0);
            f = ($urandom % 16) == 0;
            r = ($urandom % 3) != 0;
            exp_ready = !held && !f;
            drive(v, d, l, f, r);
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
            total++; if (out_valid !== held) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, held); end
            total++; if (out_vec !== model_vec()) begin bad++; $display("FAIL rnd_vec c=%0d got=%h exp=%h", c, out_vec, model_vec()); end
            total++; if (fill_count !== 3'(fields.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, fill_count, fields.size()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_reset_hold();
        if (PAD) test_pad();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
